ctrl_bubble_pipe: RTL and testbench

- Parametrised ID/EX control pipeline register with a built-in load-use hazard detector and bubble injector.
- Each cycle it either registers the decoded control bundle from ID or injects a NOP bundle into EX.
- It inserts a configurable number of bubbles per load-use hazard, honours branch flush and external hold, and counts the bubbles it inserts.
- Sits between the decoder and the EX stage; drives the PC/IF-ID stall.

---
 rtl/ctrl_bubble_pipe.sv | 111 +++++++++++
 tb/tb_ctrl_bubble_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_bubble_pipe.sv
// ============================================================================
// Module   : ctrl_bubble_pipe
// Brief    : ID/EX control pipeline register with load-use hazard detection,
//            configurable bubble injection, flush/hold handling and a
//            saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_bubble_pipe #(
    parameter int                CTRL_W       = 13,
    parameter int                RA_W         = 5,
    parameter logic [CTRL_W-1:0] NOP_CTRL     = {CTRL_W{1'b0}},
    parameter int                STALL_CYCLES = 1,
    parameter int                CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              valid_i,
    input  logic [RA_W-1:0]   rd_i,
    input  logic              mem_read_i,
    input  logic [RA_W-1:0]   rs1_i,
    input  logic [RA_W-1:0]   rs2_i,
    input  logic              rs1_used_i,
    input  logic              rs2_used_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [RA_W-1:0]   rd_o,
    output logic              mem_read_o,
    output logic              valid_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [3:0] c_stall_init = 4'(STALL_CYCLES - 1);
    localparam bit         c_multi      = (STALL_CYCLES > 1);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             w_hz;
    logic [CNT_W-1:0] w_cnt_inc;

    // x0 is never a real producer, so rd_o==0 masks the comparator
    assign w_hz = valid_i & valid_o & mem_read_o & (rd_o != '0) &
                  ((rs1_used_i & (rs1_i == rd_o)) |
                   (rs2_used_i & (rs2_i == rd_o)));

    assign stall_o = rst_n_i & ~flush_i &
                     (((r_state == ST_RUN) & w_hz) | (r_state == ST_STALL));

    assign w_cnt_inc = (bubble_cnt_o == {CNT_W{1'b1}}) ? bubble_cnt_o
                                                        : bubble_cnt_o + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ctrl_o       <= NOP_CTRL;
            rd_o         <= '0;
            mem_read_o   <= 1'b0;
            valid_o      <= 1'b0;
            bubble_cnt_o <= '0;
            r_state      <= ST_RUN;
            r_cnt        <= '0;
        end else if (flush_i) begin
            ctrl_o       <= NOP_CTRL;
            rd_o         <= '0;
            mem_read_o   <= 1'b0;
            valid_o      <= 1'b0;
            bubble_cnt_o <= w_cnt_inc;
            r_state      <= ST_RUN;
            r_cnt        <= '0;
        end else if (hold_i) begin
            ctrl_o       <= ctrl_o;
        end else if ((r_state == ST_RUN) && w_hz) begin
            ctrl_o       <= NOP_CTRL;
            rd_o         <= '0;
            mem_read_o   <= 1'b0;
            valid_o      <= 1'b0;
            bubble_cnt_o <= w_cnt_inc;
            if (c_multi) begin
                r_state <= ST_STALL;
                r_cnt   <= c_stall_init;
            end
        end else if (r_state == ST_STALL) begin
            // Comparator ignored here: EX already holds a bubble
            ctrl_o       <= NOP_CTRL;
            rd_o         <= '0;
            mem_read_o   <= 1'b0;
            valid_o      <= 1'b0;
            bubble_cnt_o <= w_cnt_inc;
            r_cnt        <= r_cnt - 1'b1;
            if (r_cnt == 4'd1) begin
                r_state <= ST_RUN;
            end
        end else begin
            ctrl_o     <= ctrl_i;
            rd_o       <= rd_i;
            mem_read_o <= mem_read_i;
            valid_o    <= valid_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_bubble_pipe.sv
// Scoreboard bench: two configurations (1 bubble / 3 bubbles with a narrow
// counter) share stimulus and are checked against a bubbles-remaining model.
`default_nettype none

module tb_ctrl_bubble_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] ctrl;
    logic        valid, mem_read, rs1_used, rs2_used, flush, hold;
    logic [4:0]  rd, rs1, rs2;

    logic [12:0] ctrl_a, ctrl_b;
    logic [4:0]  rd_a, rd_b;
    logic        mr_a, mr_b, v_a, v_b, st_a, st_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    ctrl_bubble_pipe #(.STALL_CYCLES(1), .CNT_W(16)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .ctrl_i(ctrl), .valid_i(valid), .rd_i(rd),
        .mem_read_i(mem_read), .rs1_i(rs1), .rs2_i(rs2), .rs1_used_i(rs1_used),
        .rs2_used_i(rs2_used), .flush_i(flush), .hold_i(hold), .ctrl_o(ctrl_a),
        .rd_o(rd_a), .mem_read_o(mr_a), .valid_o(v_a), .stall_o(st_a),
        .bubble_cnt_o(cnt_a));

    ctrl_bubble_pipe #(.STALL_CYCLES(3), .CNT_W(4)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .ctrl_i(ctrl), .valid_i(valid), .rd_i(rd),
        .mem_read_i(mem_read), .rs1_i(rs1), .rs2_i(rs2), .rs1_used_i(rs1_used),
        .rs2_used_i(rs2_used), .flush_i(flush), .hold_i(hold), .ctrl_o(ctrl_b),
        .rd_o(rd_b), .mem_read_o(mr_b), .valid_o(v_b), .stall_o(st_b),
        .bubble_cnt_o(cnt_b));

    typedef struct packed {
        logic [12:0] ctrl;
        logic [4:0]  rd;
        logic        mr;
        logic        v;
        logic [15:0] cnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int total = 0;
    int bad   = 0;

    // Model: EX contents plus number of bubbles still owed to the current hazard
    logic [12:0] m_ctrl[2];
    logic [4:0]  m_rd[2];
    logic        m_mr[2];
    logic        m_v[2];
    int          m_pend[2];
    int          m_cnt[2];
    int          m_stalls[2] = '{1, 3};
    int          m_max[2]    = '{65535, 15};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ctrl[k] = '0; m_rd[k] = '0; m_mr[k] = 1'b0; m_v[k] = 1'b0;
            m_pend[k] = 0;  m_cnt[k] = 0;
        end
    endtask

    task automatic model_bubble(input int k);
        m_ctrl[k] = '0; m_rd[k] = '0; m_mr[k] = 1'b0; m_v[k] = 1'b0;
        if (m_cnt[k] < m_max[k]) m_cnt[k]++;
    endtask

    task automatic step(input logic r, input logic [12:0] c, input logic v,
                        input logic [4:0] d, input logic mr,
                        input logic [4:0] a1, input logic u1,
                        input logic [4:0] a2, input logic u2,
                        input logic fl, input logic hd);
        logic hz;
        logic exp_stall;
        exp_t e;
        @(negedge clk);
        rst_n = r; ctrl = c; valid = v; rd = d; mem_read = mr;
        rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2; flush = fl; hold = hd;
        #1;
        for (int k = 0; k < 2; k++) begin
            hz = v && m_v[k] && m_mr[k] && (m_rd[k] != 0) &&
                 ((u1 && a1 == m_rd[k]) || (u2 && a2 == m_rd[k]));
            exp_stall = r && !fl && (m_pend[k] > 0 || hz);
            if (k == 0) chk("stall_s1", {31'b0, st_a}, {31'b0, exp_stall});
            else        chk("stall_s3", {31'b0, st_b}, {31'b0, exp_stall});
            if (!r) begin
                model_reset();
                m_pend[k] = 0;
            end else if (fl) begin
                model_bubble(k);
                m_pend[k] = 0;
            end else if (hd) begin
                // frozen
            end else if (m_pend[k] > 0) begin
                model_bubble(k);
                m_pend[k]--;
            end else if (hz) begin
                model_bubble(k);
                m_pend[k] = m_stalls[k] - 1;
            end else begin
                m_ctrl[k] = c; m_rd[k] = d; m_mr[k] = mr; m_v[k] = v;
            end
            e.ctrl = m_ctrl[k]; e.rd = m_rd[k]; e.mr = m_mr[k]; e.v = m_v[k];
            e.cnt = 16'(m_cnt[k]);
            if (k == 0) q_a.push_back(e);
            else        q_b.push_back(e);
        end
    endtask

    // Monitor: every edge produces an EX-stage bundle to compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk("ctrl_s1", {19'b0, ctrl_a}, {19'b0, e.ctrl});
                chk("rd_s1",   {27'b0, rd_a},   {27'b0, e.rd});
                chk("mr_s1",   {31'b0, mr_a},   {31'b0, e.mr});
                chk("vld_s1",  {31'b0, v_a},    {31'b0, e.v});
                chk("cnt_s1",  {16'b0, cnt_a},  {16'b0, e.cnt});
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                chk("ctrl_s3", {19'b0, ctrl_b}, {19'b0, e.ctrl});
                chk("rd_s3",   {27'b0, rd_b},   {27'b0, e.rd});
                chk("mr_s3",   {31'b0, mr_b},   {31'b0, e.mr});
                chk("vld_s3",  {31'b0, v_b},    {31'b0, e.v});
                chk("cnt_s3",  {28'b0, cnt_b},  {16'b0, e.cnt});
            end
        end
    end

    initial begin
        int budget;
        rst_n = 1'b0; ctrl = 13'h1FFF; valid = 1'b1; rd = '0; mem_read = 1'b0;
        rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0; flush = 1'b0; hold = 1'b0;
        model_reset();

        step(0, 13'h1FFF, 1, 5'd3, 1, 0, 0, 0, 0, 0, 0);
        step(0, 13'h1FFF, 1, 5'd3, 1, 0, 0, 0, 0, 0, 0);
        step(1, 13'h00A5, 1, 5'd5, 1, 0, 0, 0, 0, 0, 0);
        // load-use on rs1 held until the stall drains
        repeat (4) step(1, 13'h0123, 1, 5'd6, 0, 5'd5, 1, 5'd1, 0, 0, 0);
        // rd==0 load and unused rs2 never stall
        step(1, 13'h0777, 1, 5'd0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 13'h0456, 1, 5'd7, 1, 5'd0, 1, 5'd0, 1, 0, 0);
        step(1, 13'h0321, 1, 5'd2, 0, 5'd1, 1, 5'd7, 0, 0, 0);
        // flush on the second stall cycle
        step(1, 13'h0111, 1, 5'd5, 1, 0, 0, 0, 0, 0, 0);
        step(1, 13'h0222, 1, 5'd6, 0, 5'd5, 1, 0, 0, 0, 0);
        step(1, 13'h0222, 1, 5'd6, 0, 5'd5, 1, 0, 0, 1, 0);
        step(1, 13'h0333, 1, 5'd6, 0, 5'd5, 1, 0, 0, 0, 0);
        // hold in the middle of a stall
        step(1, 13'h0444, 1, 5'd9, 1, 0, 0, 0, 0, 0, 0);
        step(1, 13'h0555, 1, 5'd1, 0, 5'd2, 0, 5'd9, 1, 0, 0);
        step(1, 13'h0555, 1, 5'd1, 0, 5'd2, 0, 5'd9, 1, 0, 1);
        step(1, 13'h0555, 1, 5'd1, 0, 5'd2, 0, 5'd9, 1, 0, 1);
        repeat (3) step(1, 13'h0555, 1, 5'd1, 0, 5'd2, 0, 5'd9, 1, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 13'($urandom),
                 ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 3)),
                 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        budget = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (q_a.size() > 0 || q_b.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q_a.size(), q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
